// File: rtl/toggle_event_receiver.sv
// toggle_event_receiver
// Receives a toggle-encoded event line from another clock domain. Each
// transition on toggle_in (either polarity) becomes one event: a one-cycle
// event_pulse plus an increment of a saturating pending counter. The consumer
// drains pending through a valid/ready handshake. A sticky overflow flag records
// any event dropped because the counter was already full.
module toggle_event_receiver #(
    parameter int SYNC_STAGES = 2,  // synchroniser depth, must be >= 2
    parameter int CNT_W       = 4   // pending counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             toggle_in,
    input  logic             evt_ready,
    input  logic             clr_overflow,
    output logic             event_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic                   ovf_q, ovf_d;

    logic                   sync_out;
    logic                   det;
    logic                   accept;
    logic                   at_max;
    logic                   set_ovf;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign det      = sync_out ^ prev_q;
    assign at_max   = (pend_q == PEND_MAX);
    assign accept   = evt_valid & evt_ready;
    // A detected event with no simultaneous accept and a full counter is lost.
    assign set_ovf  = det & ~accept & at_max;

    // Synchroniser chain: toggle_in lands directly in stage 0 with no logic ahead of it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop gets a reset value of 0, matching the sender's cleared q,
        // so nothing here can start as X and no spurious event appears at startup.
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep each stage sampling the previous
            // stage's old value, which is what makes this a shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_in};
        end
    end

    // Edge detector: remember the last synchronised level and register the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= sync_out;
            pulse_q <= det;
        end
    end

    // Next-state logic for the saturating pending counter and sticky overflow.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch forms.
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (det && !accept) begin
            if (!at_max) begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (!det && accept) begin
            // accept implies pend_q != 0, so this never wraps below zero.
            pend_d = pend_q - PEND_ONE;
        end
        // Setting wins over a clear requested in the same cycle.
        if (set_ovf) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    // Counter and overflow state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign event_pulse = pulse_q;
    assign pending     = pend_q;
    assign overflow    = ovf_q;
    assign evt_valid   = (pend_q != '0);

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Bench for toggle_event_receiver. Two instances share the stimulus: one with
// the default 4-bit counter and one with a 2-bit counter so saturation is
// reached quickly. A behavioural model keeps a history of sampled toggle_in
// levels and derives events from level differences SYNC_STAGES samples back.
module tb_toggle_event_receiver;

    localparam int SS    = 2;
    localparam int WA    = 4;
    localparam int WB    = 2;
    localparam int MAX_A = 15;
    localparam int MAX_B = 3;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          toggle_in    = 1'b0;
    logic          evt_ready    = 1'b0;
    logic          clr_overflow = 1'b0;

    logic          pulse_a, valid_a, ovf_a;
    logic [WA-1:0] pend_a;
    logic          pulse_b, valid_b, ovf_b;
    logic [WB-1:0] pend_b;

    logic [6:0]    obs_a;
    logic [4:0]    obs_b;

    int            checks = 0;
    int            errors = 0;

    // Reference model state
    bit            samp[$];
    int            m_pend_a, m_pend_b;
    bit            m_ovf_a, m_ovf_b, m_pulse;

    always #5 clk = ~clk;

    toggle_event_receiver #(.SYNC_STAGES(SS), .CNT_W(WA)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .toggle_in    (toggle_in),
        .evt_ready    (evt_ready),
        .clr_overflow (clr_overflow),
        .event_pulse  (pulse_a),
        .evt_valid    (valid_a),
        .pending      (pend_a),
        .overflow     (ovf_a)
    );

    toggle_event_receiver #(.SYNC_STAGES(SS), .CNT_W(WB)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .toggle_in    (toggle_in),
        .evt_ready    (evt_ready),
        .clr_overflow (clr_overflow),
        .event_pulse  (pulse_b),
        .evt_valid    (valid_b),
        .pending      (pend_b),
        .overflow     (ovf_b)
    );

    assign obs_a = {pulse_a, valid_a, ovf_a, pend_a};
    assign obs_b = {pulse_b, valid_b, ovf_b, pend_b};

    function automatic logic [6:0] exp_a();
        return {m_pulse, m_pend_a != 0, m_ovf_a, 4'(m_pend_a)};
    endfunction

    function automatic logic [4:0] exp_b();
        return {m_pulse, m_pend_b != 0, m_ovf_b, 2'(m_pend_b)};
    endfunction

    task automatic model_reset();
        samp.delete();
        repeat (SS + 1) samp.push_back(1'b0);
        m_pend_a = 0;
        m_pend_b = 0;
        m_ovf_a  = 1'b0;
        m_ovf_b  = 1'b0;
        m_pulse  = 1'b0;
    endtask

    // Apply the counter rules for one clock edge to one counter of size max.
    task automatic upd(input int max, input bit det, inout int pend, inout bit ovf);
        bit acc;
        bit lost;
        acc  = evt_ready && (pend != 0);
        lost = det && !acc && (pend == max);
        if (det && !acc && pend < max) pend = pend + 1;
        else if (!det && acc)          pend = pend - 1;
        ovf = lost || (ovf && !clr_overflow);
    endtask

    // Advance model and DUT by one clock edge; returns 1 time unit after the edge.
    task automatic tick();
        bit det;
        if (!rst_n) begin
            model_reset();
            @(posedge clk);
            #1;
            return;
        end
        samp.push_back(toggle_in);
        det = samp[samp.size() - 1 - SS] != samp[samp.size() - 2 - SS];
        void'(samp.pop_front());
        upd(MAX_A, det, m_pend_a, m_ovf_a);
        upd(MAX_B, det, m_pend_b, m_ovf_b);
        m_pulse = det;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        evt_ready    = 1'b1;
        clr_overflow = 1'b1;
        repeat (MAX_A + 1) tick();
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        tick();
        checks++;
        if (obs_a !== 7'd0 || obs_b !== 5'd0) begin
            errors++;
            $display("FAIL drain_idle got a=%b b=%b expected all zero", obs_a, obs_b);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        toggle_in = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_a !== 7'd0 || obs_b !== 5'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got a=%b b=%b expected zero", i, obs_a, obs_b);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs_a !== 7'd0 || obs_b !== 5'd0) begin
                errors++;
                $display("FAIL reset_quiet cyc %0d got a=%b b=%b expected zero", i, obs_a, obs_b);
            end
        end
    endtask

    task automatic test_single_event();
        evt_ready = 1'b0;
        toggle_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_a() || obs_b !== exp_b()) begin
                errors++;
                $display("FAIL single_model cyc %0d got a=%b b=%b expected a=%b b=%b",
                         i, obs_a, obs_b, exp_a(), exp_b());
            end
            checks++;
            if (pulse_a !== (i == 3)) begin
                errors++;
                $display("FAIL single_pulse cyc %0d got %b expected %b", i, pulse_a, (i == 3));
            end
        end
        checks++;
        if (pend_a !== 4'd1 || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL single_pending got %0d/%b expected 1/1", pend_a, valid_a);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        checks++;
        if (pend_a !== 4'd0 || valid_a !== 1'b0 || obs_a !== exp_a()) begin
            errors++;
            $display("FAIL single_accept got pend=%0d valid=%b expected 0/0", pend_a, valid_a);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses    = 0;
        evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) toggle_in = ~toggle_in;
            tick();
            pulses += int'(pulse_a);
            checks++;
            if (obs_a !== exp_a() || obs_b !== exp_b()) begin
                errors++;
                $display("FAIL b2b_model cyc %0d got a=%b b=%b expected a=%b b=%b",
                         i, obs_a, obs_b, exp_a(), exp_b());
            end
        end
        checks++;
        if (pulses != 6 || pend_a !== 4'd6 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_totals got pulses=%0d pend=%0d ovf=%b expected 6/6/0",
                     pulses, pend_a, ovf_a);
        end
    endtask

    task automatic test_saturation();
        evt_ready = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (t % 2 == 0 && t < 10) toggle_in = ~toggle_in;
            tick();
            checks++;
            if (obs_a !== exp_a() || obs_b !== exp_b()) begin
                errors++;
                $display("FAIL sat_model cyc %0d got a=%b b=%b expected a=%b b=%b",
                         t, obs_a, obs_b, exp_a(), exp_b());
            end
            checks++;
            if (ovf_b !== (t >= 8)) begin
                errors++;
                $display("FAIL sat_ovf_timing cyc %0d got %b expected %b", t, ovf_b, (t >= 8));
            end
        end
        checks++;
        if (pend_b !== 2'd3 || pend_a !== 4'd5) begin
            errors++;
            $display("FAIL sat_level got b=%0d a=%0d expected 3/5", pend_b, pend_a);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (ovf_b !== 1'b0 || pend_b !== 2'd3 || obs_b !== exp_b()) begin
            errors++;
            $display("FAIL sat_clear got ovf=%b pend=%0d expected 0/3", ovf_b, pend_b);
        end
    endtask

    task automatic test_detect_accept();
        int seq_a[5] = '{2, 1, 1, 0, 0};
        // Phase A: pending 2, event lands on the second accepting edge
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 2) toggle_in = ~toggle_in;
            tick();
        end
        toggle_in = ~toggle_in;
        for (int e = 0; e < 5; e++) begin
            if (e == 1) evt_ready = 1'b1;
            tick();
            checks++;
            if (int'(pend_a) != seq_a[e] || obs_a !== exp_a() || obs_b !== exp_b()) begin
                errors++;
                $display("FAIL da_seq edge %0d got a=%b b=%b expected pend_a=%0d a=%b b=%b",
                         e, obs_a, obs_b, seq_a[e], exp_a(), exp_b());
            end
        end
        evt_ready = 1'b0;
        drain();
        // Phase B: dut_b full, event and accept on the same edge
        for (int i = 0; i < 6; i++) begin
            if (i < 3) toggle_in = ~toggle_in;
            tick();
        end
        toggle_in = ~toggle_in;
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        checks++;
        if (pend_b !== 2'd3 || ovf_b !== 1'b0 || pulse_b !== 1'b1 || obs_b !== exp_b()
            || obs_a !== exp_a()) begin
            errors++;
            $display("FAIL da_at_max got b=%b a=%b expected b=%b a=%b",
                     obs_b, obs_a, exp_b(), exp_a());
        end
    endtask

    task automatic test_random();
        int ready_pct;
        for (int i = 0; i < 600; i++) begin
            ready_pct    = (i < 300) ? 25 : 75;
            if ($urandom_range(1, 0) == 1) toggle_in = ~toggle_in;
            evt_ready    = ($urandom_range(99, 0) < ready_pct);
            clr_overflow = ($urandom_range(15, 0) == 0);
            tick();
            checks++;
            if (obs_a !== exp_a() || obs_b !== exp_b()) begin
                errors++;
                $display("FAIL random cyc %0d got a=%b b=%b expected a=%b b=%b",
                         i, obs_a, obs_b, exp_a(), exp_b());
            end
        end
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pulses;
        evt_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) toggle_in = ~toggle_in;
            tick();
        end
        evt_ready = 1'b1;
        tick();
        tick();
        evt_ready = 1'b0;
        checks++;
        if (pend_a !== 4'd2 || ovf_b !== 1'b1 || obs_a !== exp_a() || obs_b !== exp_b()) begin
            errors++;
            $display("FAIL rmid_setup got a=%b b=%b expected a=%b b=%b",
                     obs_a, obs_b, exp_a(), exp_b());
        end
        toggle_in = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_a !== 7'd0 || obs_b !== 5'd0) begin
            errors++;
            $display("FAIL rmid_async got a=%b b=%b expected zero before edge", obs_a, obs_b);
        end
        model_reset();
        tick();
        tick();
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(pulse_a);
            checks++;
            if (obs_a !== exp_a() || obs_b !== exp_b()) begin
                errors++;
                $display("FAIL rmid_release cyc %0d got a=%b b=%b expected a=%b b=%b",
                         i, obs_a, obs_b, exp_a(), exp_b());
            end
        end
        checks++;
        if (pulses != 1 || pend_a !== 4'd1 || pend_b !== 2'd1) begin
            errors++;
            $display("FAIL rmid_count got pulses=%0d pend_a=%0d pend_b=%0d expected 1/1/1",
                     pulses, pend_a, pend_b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_event();
        test_back_to_back();
        drain();
        test_saturation();
        drain();
        test_detect_accept();
        drain();
        test_random();
        drain();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
